thread_scheduler: RTL and testbench

- Fine-grained multithreading scheduler that feeds the per-thread PC/status store.
- Consumes the per-thread status vector and chooses the active thread by round-robin.
- Drives the PC read-thread select with the active thread.
- Requests context switches from the frontend through a valid/ready handshake, on quantum expiry, on an external switch event, or when the active thread stops being ready.

---
 rtl/thread_scheduler.sv | 138 +++++++++++++
 tb/tb_thread_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_scheduler.sv
// Round-robin fine-grained multithreading scheduler: picks the active thread, requests
// frontend context switches via valid/ready. Define THREAD_SCHED_SWITCH_CNT_EN for switch_count_o.
package thread_sched_pkg;
   typedef enum logic [1:0] {
      TS_HALTED  = 2'd0,
      TS_READY   = 2'd1,
      TS_BLOCKED = 2'd2,
      TS_WAITING = 2'd3
   } thread_status_t;
endpackage

module thread_scheduler
   import thread_sched_pkg::*;
#(
   parameter  int NUM_THREADS = 4,
   parameter  int QUANTUM     = 16,
   localparam int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  thread_status_t [NUM_THREADS-1:0] all_threads_status_i,
   input  logic                             switch_req_i,
   input  logic                             fetch_ready_i,
   output logic                             switch_valid_o,
   output logic [TW-1:0]                    next_thread_id_o,
   output logic [TW-1:0]                    active_thread_id_o,
   output logic                             idle_o,
   output logic [31:0]                      switch_count_o
);

   localparam int CW = $clog2(QUANTUM + 1);

   typedef enum logic [1:0] {ST_RUN, ST_SWITCH, ST_IDLE} state_t;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [NUM_THREADS-1:0] rdy;
   logic                   act_rdy;
   logic                   sel_found;
   logic [TW-1:0]          sel_id;
   logic                   trigger;

   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++) begin
         rdy[i] = (all_threads_status_i[i] == TS_READY);
      end
   end

   // Round-robin pick: the ready thread at the smallest forward distance from the
   // active one, where the active thread itself counts as the farthest (distance N).
   always_comb begin
      int best;
      int d;
      best      = NUM_THREADS + 1;
      d         = 0;
      sel_found = 1'b0;
      sel_id    = '0;
      act_rdy   = 1'b0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         d = i - int'(active_thread_id_o);
         if (d <= 0) d = d + NUM_THREADS;
         if (rdy[i] && (d < best)) begin
            best      = d;
            sel_found = 1'b1;
            sel_id    = TW'(i);
         end
         if (TW'(i) == active_thread_id_o) act_rdy = rdy[i];
      end
   end

   assign trigger = (cnt_q == CW'(QUANTUM - 1)) || switch_req_i || !act_rdy;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q            <= ST_RUN;
         active_thread_id_o <= '0;
         next_thread_id_o   <= '0;
         cnt_q              <= '0;
         switch_valid_o     <= 1'b0;
         idle_o             <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (trigger) begin
                  if (!sel_found) begin
                     idle_o  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else if (sel_id == active_thread_id_o) begin
                     cnt_q <= '0;
                  end else begin
                     next_thread_id_o <= sel_id;
                     switch_valid_o   <= 1'b1;
                     state_q          <= ST_SWITCH;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // Target is held until accepted even if it stops being ready; RUN re-selects.
            ST_SWITCH: begin
               if (fetch_ready_i) begin
                  active_thread_id_o <= next_thread_id_o;
                  cnt_q              <= '0;
                  switch_valid_o     <= 1'b0;
                  state_q            <= ST_RUN;
               end
            end
            ST_IDLE: begin
               if (sel_found) begin
                  idle_o <= 1'b0;
                  if (sel_id == active_thread_id_o) begin
                     cnt_q   <= '0;
                     state_q <= ST_RUN;
                  end else begin
                     next_thread_id_o <= sel_id;
                     switch_valid_o   <= 1'b1;
                     state_q          <= ST_SWITCH;
                  end
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

`ifdef THREAD_SCHED_SWITCH_CNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         switch_count_o <= '0;
      end else if (switch_valid_o && fetch_ready_i && (switch_count_o != 32'hFFFF_FFFF)) begin
         switch_count_o <= switch_count_o + 32'd1;
      end
   end
`else
   assign switch_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Bench for thread_scheduler (4 threads, quantum 4): directed scenarios plus a randomized
// run against a slice/pending-switch reference model.
module tb_thread_scheduler;
   import thread_sched_pkg::*;

   localparam int NT = 4;
   localparam int Q  = 4;

   logic                    clk_i  = 1'b0;
   logic                    rst_ni = 1'b1;
   thread_status_t [NT-1:0] status;
   logic                    switch_req;
   logic                    fetch_ready;
   logic                    switch_valid_o;
   logic [1:0]              next_thread_id_o;
   logic [1:0]              active_thread_id_o;
   logic                    idle_o;
   logic [31:0]             switch_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: which thread runs, how much of its slice is used, pending target
   int m_active, m_pend, m_next, m_used, m_count;
   bit m_idle;

   thread_scheduler #(.NUM_THREADS(NT), .QUANTUM(Q)) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .all_threads_status_i(status),
      .switch_req_i        (switch_req),
      .fetch_ready_i       (fetch_ready),
      .switch_valid_o      (switch_valid_o),
      .next_thread_id_o    (next_thread_id_o),
      .active_thread_id_o  (active_thread_id_o),
      .idle_o              (idle_o),
      .switch_count_o      (switch_count_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [NT-1:0] ready_vec(input thread_status_t [NT-1:0] s);
      logic [NT-1:0] r;
      for (int i = 0; i < NT; i++) r[i] = (s[i] == TS_READY);
      return r;
   endfunction

   function automatic int pick(input logic [NT-1:0] r, input int from);
      int t;
      for (int k = 1; k <= NT; k++) begin
         t = (from + k) % NT;
         if (r[2'(t)]) return t;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [NT-1:0] r, input logic req, input logic fr);
      int t;
      if (m_pend >= 0) begin
         if (fr) begin
            m_active = m_pend;
            m_pend   = -1;
            m_used   = 0;
            m_count++;
         end
      end else if (m_idle) begin
         t = pick(r, m_active);
         if (t >= 0) begin
            m_idle = 0;
            if (t == m_active) m_used = 0;
            else begin m_pend = t; m_next = t; end
         end
      end else if (m_used == Q - 1 || req || !r[2'(m_active)]) begin
         t = pick(r, m_active);
         if (t < 0) m_idle = 1;
         else if (t == m_active) m_used = 0;
         else begin m_pend = t; m_next = t; end
      end else begin
         m_used++;
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ready(input logic [NT-1:0] r);
      for (int i = 0; i < NT; i++) status[i] = r[i] ? TS_READY : ((i % 2) != 0 ? TS_BLOCKED : TS_HALTED);
   endtask

   task automatic do_reset(input logic [NT-1:0] r);
      rst_ni      = 1'b0;
      switch_req  = 1'b0;
      fetch_ready = 1'b0;
      set_ready(r);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      switch_req  = 1'b0;
      fetch_ready = 1'b0;
      set_ready(4'b0001);
      #2 rst_ni = 1'b0;
      #1;
      n_checks++; if (active_thread_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_active: got %0d want 0", active_thread_id_o); end
      n_checks++; if (next_thread_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_next: got %0d want 0", next_thread_id_o); end
      n_checks++; if (switch_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", switch_valid_o); end
      n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %0b want 0", idle_o); end
      n_checks++; if (switch_count_o !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", switch_count_o); end
      do_reset(4'b0001);
   endtask

   task automatic test_single_thread();
      do_reset(4'b0001);
      for (int c = 0; c < 20; c++) begin
         tick();
         n_checks++;
         if ({active_thread_id_o, switch_valid_o, idle_o} !== 4'b0000) begin
            n_fail++; $display("FAIL single_thread cyc %0d: act/vld/idle got %h want 0", c, {active_thread_id_o, switch_valid_o, idle_o});
         end
      end
   endtask

   task automatic test_quantum_switch();
      do_reset(4'b0101);
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++; if ({active_thread_id_o, switch_valid_o} !== 3'b000) begin n_fail++; $display("FAIL quantum_early cyc %0d: act/vld got %h want 0", c, {active_thread_id_o, switch_valid_o}); end
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++; if ({switch_valid_o, next_thread_id_o, active_thread_id_o} !== 5'b1_10_00) begin n_fail++; $display("FAIL quantum_pending cyc %0d: vld/next/act got %h want 18", c, {switch_valid_o, next_thread_id_o, active_thread_id_o}); end
      end
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      n_checks++; if ({active_thread_id_o, switch_valid_o} !== 3'b10_0) begin n_fail++; $display("FAIL quantum_accept: act/vld got %h want 4", {active_thread_id_o, switch_valid_o}); end
   endtask

   task automatic test_switch_req_wrap();
      do_reset(4'b1000);
      tick();
      n_checks++; if ({switch_valid_o, next_thread_id_o} !== 3'b1_11) begin n_fail++; $display("FAIL wrap_setup: vld/next got %h want 7", {switch_valid_o, next_thread_id_o}); end
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      set_ready(4'b1011);
      tick();
      switch_req = 1'b1;
      tick();
      switch_req = 1'b0;
      n_checks++; if ({switch_valid_o, next_thread_id_o, active_thread_id_o} !== 5'b1_00_11) begin n_fail++; $display("FAIL wrap_next: vld/next/act got %h want 13", {switch_valid_o, next_thread_id_o, active_thread_id_o}); end
      switch_req = 1'b1;
      tick();
      switch_req = 1'b0;
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      n_checks++; if ({active_thread_id_o, switch_valid_o} !== 3'b00_0) begin n_fail++; $display("FAIL wrap_accept: act/vld got %h want 0", {active_thread_id_o, switch_valid_o}); end
      tick();
      n_checks++; if (switch_valid_o !== 1'b0) begin n_fail++; $display("FAIL req_ignored_in_switch: vld got %0b want 0", switch_valid_o); end
      repeat (2) tick();
      switch_req = 1'b1;
      tick();
      switch_req = 1'b0;
      n_checks++; if ({switch_valid_o, next_thread_id_o} !== 3'b1_01) begin n_fail++; $display("FAIL req_and_expiry: vld/next got %h want 5", {switch_valid_o, next_thread_id_o}); end
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      tick();
      n_checks++; if ({active_thread_id_o, switch_valid_o} !== 3'b01_0) begin n_fail++; $display("FAIL single_switch: act/vld got %h want 2", {active_thread_id_o, switch_valid_o}); end
   endtask

   task automatic test_idle();
      do_reset(4'b0001);
      repeat (2) tick();
      set_ready(4'b0000);
      tick();
      n_checks++; if ({idle_o, switch_valid_o} !== 2'b10) begin n_fail++; $display("FAIL idle_enter: idle/vld got %b want 10", {idle_o, switch_valid_o}); end
      tick();
      n_checks++; if ({idle_o, switch_valid_o} !== 2'b10) begin n_fail++; $display("FAIL idle_hold: idle/vld got %b want 10", {idle_o, switch_valid_o}); end
      set_ready(4'b0010);
      tick();
      n_checks++; if ({idle_o, switch_valid_o, next_thread_id_o} !== 4'b0_1_01) begin n_fail++; $display("FAIL idle_exit: idle/vld/next got %h want 5", {idle_o, switch_valid_o, next_thread_id_o}); end
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      n_checks++; if ({active_thread_id_o, switch_valid_o, idle_o} !== 4'b01_0_0) begin n_fail++; $display("FAIL idle_accept: act/vld/idle got %h want 4", {active_thread_id_o, switch_valid_o, idle_o}); end
   endtask

   task automatic test_reset_mid_switch();
      do_reset(4'b0010);
      tick();
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      set_ready(4'b0110);
      repeat (4) tick();
      n_checks++; if ({switch_valid_o, next_thread_id_o, active_thread_id_o} !== 5'b1_10_01) begin n_fail++; $display("FAIL midsw_setup: vld/next/act got %h want 19", {switch_valid_o, next_thread_id_o, active_thread_id_o}); end
      #2 rst_ni = 1'b0;
      #1;
      n_checks++; if ({switch_valid_o, next_thread_id_o, active_thread_id_o} !== 5'b0) begin n_fail++; $display("FAIL midsw_async: vld/next/act got %h want 0", {switch_valid_o, next_thread_id_o, active_thread_id_o}); end
      set_ready(4'b0001);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_checks++; if ({active_thread_id_o, switch_valid_o, idle_o} !== 4'b0000) begin n_fail++; $display("FAIL midsw_resume cyc %0d: act/vld/idle got %h want 0", c, {active_thread_id_o, switch_valid_o, idle_o}); end
      end
   endtask

   task automatic test_switch_count();
      int exp_cnt;
`ifdef THREAD_SCHED_SWITCH_CNT_EN
      exp_cnt = 10;
`else
      exp_cnt = 0;
`endif
      do_reset(4'b0011);
      fetch_ready = 1'b1;
      repeat (50) tick();
      fetch_ready = 1'b0;
      n_checks++; if (switch_count_o !== 32'(exp_cnt)) begin n_fail++; $display("FAIL switch_count: got %0d want %0d", switch_count_o, exp_cnt); end
      n_checks++; if ({active_thread_id_o, switch_valid_o} !== 3'b000) begin n_fail++; $display("FAIL count_final: act/vld got %h want 0", {active_thread_id_o, switch_valid_o}); end
   endtask

   task automatic test_random();
      int ti, exp_cnt;
      do_reset(4'b1111);
      m_active = 0; m_pend = -1; m_next = 0; m_used = 0; m_count = 0; m_idle = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            ti = $urandom_range(0, NT - 1);
            status[ti] = ($urandom_range(0, 2) != 0) ? TS_READY : thread_status_t'($urandom_range(0, 3));
         end
         switch_req  = ($urandom_range(0, 7) == 0);
         fetch_ready = $urandom_range(0, 1);
         @(posedge clk_i);
         model_step(ready_vec(status), switch_req, fetch_ready);
         #1;
`ifdef THREAD_SCHED_SWITCH_CNT_EN
         exp_cnt = m_count;
`else
         exp_cnt = 0;
`endif
         n_checks++; if (active_thread_id_o !== 2'(m_active)) begin n_fail++; $display("FAIL rand_active cyc %0d: got %0d want %0d", c, active_thread_id_o, m_active); end
         n_checks++; if (switch_valid_o !== (m_pend >= 0)) begin n_fail++; $display("FAIL rand_valid cyc %0d: got %0b want %0b", c, switch_valid_o, m_pend >= 0); end
         n_checks++; if (idle_o !== m_idle) begin n_fail++; $display("FAIL rand_idle cyc %0d: got %0b want %0b", c, idle_o, m_idle); end
         n_checks++; if (switch_count_o !== 32'(exp_cnt)) begin n_fail++; $display("FAIL rand_count cyc %0d: got %0d want %0d", c, switch_count_o, exp_cnt); end
         if (m_pend >= 0) begin
            n_checks++; if (next_thread_id_o !== 2'(m_next)) begin n_fail++; $display("FAIL rand_next cyc %0d: got %0d want %0d", c, next_thread_id_o, m_next); end
         end
      end
      switch_req  = 1'b0;
      fetch_ready = 1'b0;
   endtask

   initial begin
      switch_req  = 1'b0;
      fetch_ready = 1'b0;
      set_ready(4'b0001);
      test_reset();
      test_single_thread();
      test_quantum_switch();
      test_switch_req_wrap();
      test_idle();
      test_reset_mid_switch();
      test_switch_count();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
